mem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-port LC-3 main memory. It shares the memory between an instruction-fetch requester (I) and a load/store requester (D), and drives the memory's MEM_EN/RW/MAR/MDR inputs. It also runs the enable/ready (R) handshake, returns read data, and rejects out-of-range or timed-out accesses with an error response. It sits between the control unit / datapath and the memory block.

---
 rtl/mem_arbiter_if.sv | 30 +++
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port, load/store port, and the LC-3 memory strobes.
// The arbiter uses the slave view; requesters and memory use the master view.
interface mem_arbiter_if;
  logic        I_REQ;
  logic [15:0] I_ADDR;
  logic        I_ACK;
  logic        D_REQ;
  logic        D_RW;
  logic [15:0] D_ADDR;
  logic [15:0] D_WDATA;
  logic        D_ACK;
  logic [15:0] RDATA;
  logic        ERR;
  logic        MEM_EN;
  logic        RW;
  logic [15:0] MAR_OUT;
  logic [15:0] MDR_OUT;
  logic [15:0] MEM_OUT;
  logic        R;

  modport slave (
    input  I_REQ, I_ADDR, D_REQ, D_RW, D_ADDR, D_WDATA, MEM_OUT, R,
    output I_ACK, D_ACK, RDATA, ERR, MEM_EN, RW, MAR_OUT, MDR_OUT
  );

  modport master (
    output I_REQ, I_ADDR, D_REQ, D_RW, D_ADDR, D_WDATA, MEM_OUT, R,
    input  I_ACK, D_ACK, RDATA, ERR, MEM_EN, RW, MAR_OUT, MDR_OUT
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and access sequencer sharing one LC-3 memory between
// instruction fetch (I) and load/store (D), with range and timeout error responses.
module mem_arbiter #(
  parameter int unsigned MEM_WORDS = 28800,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic          i_Clk,
  input  logic          i_Rst_n,
  mem_arbiter_if.slave  bus
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE, REJECT} state_t;

  state_t      state;
  logic        mem_en;
  logic        rw;
  logic        i_ack;
  logic        d_ack;
  logic        err;
  logic        last_d;
  logic        gnt_d;
  logic [15:0] mar;
  logic [15:0] mdr;
  logic [15:0] rdata;
  logic [7:0]  tmo_cnt;

  logic        pick_d;
  logic [15:0] pick_addr;
  logic        addr_ok;
  logic        grant_ok;

  // A new grant waits for the memory to drop R so a stale ready is never taken.
  always_comb begin
    pick_d    = bus.D_REQ && (!bus.I_REQ || !last_d);
    pick_addr = pick_d ? bus.D_ADDR : bus.I_ADDR;
    addr_ok   = {16'd0, pick_addr} < MEM_WORDS;
    grant_ok  = !bus.R && (bus.I_REQ || bus.D_REQ) &&
                (state == IDLE || state == RELEASE);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state   <= IDLE;
      mem_en  <= 1'b0;
      rw      <= 1'b0;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      err     <= 1'b0;
      last_d  <= 1'b1;
      gnt_d   <= 1'b0;
      mar     <= 16'd0;
      mdr     <= 16'd0;
      rdata   <= 16'd0;
      tmo_cnt <= 8'd0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      err   <= 1'b0;
      if (grant_ok) begin
        gnt_d   <= pick_d;
        last_d  <= pick_d;
        mar     <= pick_addr;
        tmo_cnt <= 8'd0;
        if (pick_d) begin
          rw  <= bus.D_RW;
          mdr <= bus.D_WDATA;
        end else begin
          rw  <= 1'b0;
        end
        if (addr_ok) begin
          mem_en <= 1'b1;
          state  <= ACCESS;
        end else begin
          state  <= REJECT;
        end
      end else begin
        case (state)
          IDLE: state <= IDLE;
          ACCESS: begin
            // Ready takes priority over the timeout on the same edge.
            if (bus.R) begin
              if (!rw) rdata <= bus.MEM_OUT;
              i_ack  <= !gnt_d;
              d_ack  <= gnt_d;
              mem_en <= 1'b0;
              state  <= RELEASE;
            end else if (tmo_cnt == TIMEOUT_CNT) begin
              i_ack  <= !gnt_d;
              d_ack  <= gnt_d;
              err    <= 1'b1;
              mem_en <= 1'b0;
              state  <= RELEASE;
            end else begin
              tmo_cnt <= tmo_cnt + 8'd1;
            end
          end
          RELEASE: if (!bus.R) state <= IDLE;
          REJECT: begin
            i_ack <= !gnt_d;
            d_ack <= gnt_d;
            err   <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.MEM_EN  = mem_en;
  assign bus.RW      = rw;
  assign bus.MAR_OUT = mar;
  assign bus.MDR_OUT = mdr;
  assign bus.RDATA   = rdata;
  assign bus.ERR     = err;
  assign bus.I_ACK   = i_ack;
  assign bus.D_ACK   = d_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: behavioural LC-3 memory plus a transaction-level
// reference (round-robin pointer, memory image, last read data) for directed and random traffic.
module tb_mem_arbiter;

  localparam int unsigned WORDS = 28800;

  logic i_Clk = 1'b0;
  logic i_Rst_n = 1'b0;
  bit   mem_hold = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem_array   [65536];
  bit          mem_written [65536];
  logic [15:0] ref_mem     [65536];
  bit          ref_last_d = 1'b1;
  logic [15:0] last_rdata = 16'd0;

  mem_arbiter_if bus();

  mem_arbiter #(.MEM_WORDS(WORDS), .TIMEOUT(15)) dut (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .bus     (bus)
  );

  always #5 i_Clk = ~i_Clk;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a == 16'h3000) ? 16'h1234 : (a ^ 16'h5A3C);
  endfunction

  // Memory: R follows MEM_EN by one edge; mem_hold models a memory that never answers.
  always @(posedge i_Clk) begin
    if (bus.MEM_EN && !mem_hold) begin
      bus.R <= 1'b1;
      if (bus.RW) begin
        mem_array[bus.MAR_OUT]   <= bus.MDR_OUT;
        mem_written[bus.MAR_OUT] <= 1'b1;
      end else begin
        bus.MEM_OUT <= mem_written[bus.MAR_OUT] ? mem_array[bus.MAR_OUT] : init_val(bus.MAR_OUT);
      end
    end else begin
      bus.R <= 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit i_req, input logic [15:0] i_addr, input bit d_req,
                               input bit d_rw, input logic [15:0] d_addr, input logic [15:0] d_wdata);
    bus.I_REQ   = i_req;
    bus.I_ADDR  = i_addr;
    bus.D_REQ   = d_req;
    bus.D_RW    = d_rw;
    bus.D_ADDR  = d_addr;
    bus.D_WDATA = d_wdata;
  endtask

  // One isolated request from a single port, checked end to end against the reference.
  task automatic runSingle(input string tag, input bit is_d, input bit rw, input logic [15:0] addr,
                           input logic [15:0] wdata, input bit timeout);
    bit          exp_err;
    logic [15:0] exp_rd;
    int          exp_lat, exp_en, cyc, en_cyc;
    bit          bus_bad, got_ack;
    exp_err = (addr >= 16'(WORDS)) || timeout;
    exp_rd  = (!exp_err && !rw) ? ref_mem[addr] : last_rdata;
    exp_lat = (addr >= 16'(WORDS)) ? 2 : (timeout ? 17 : 3);
    exp_en  = (addr >= 16'(WORDS)) ? 0 : (timeout ? 16 : 2);
    if (is_d) applyStimulus(1'b0, 16'd0, 1'b1, rw, addr, wdata);
    else      applyStimulus(1'b1, addr, 1'b0, 1'b0, 16'd0, 16'd0);
    cyc = 0; en_cyc = 0; bus_bad = 1'b0; got_ack = 1'b0;
    while (!got_ack && cyc < 40) begin
      @(posedge i_Clk); #1;
      cyc++;
      if (bus.MEM_EN) begin
        en_cyc++;
        if (bus.RW !== rw || bus.MAR_OUT !== addr || (rw && bus.MDR_OUT !== wdata)) bus_bad = 1'b1;
      end
      if (bus.I_ACK || bus.D_ACK) got_ack = 1'b1;
    end
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0);
    checkOutput({tag, "_latency"}, cyc, exp_lat);
    checkOutput({tag, "_iack"}, bus.I_ACK, !is_d);
    checkOutput({tag, "_dack"}, bus.D_ACK, is_d);
    checkOutput({tag, "_err"}, bus.ERR, exp_err);
    checkOutput({tag, "_rdata"}, bus.RDATA, exp_rd);
    checkOutput({tag, "_memen_cycles"}, en_cyc, exp_en);
    checkOutput({tag, "_bus_fields"}, bus_bad, 0);
    checkOutput({tag, "_memen_at_ack"}, bus.MEM_EN, 0);
    @(posedge i_Clk); #1;
    checkOutput({tag, "_pulse_end"}, {bus.I_ACK, bus.D_ACK, bus.ERR}, 0);
    ref_last_d = is_d;
    if (is_d && rw && !exp_err) ref_mem[addr] = wdata;
    last_rdata = exp_rd;
    repeat (2) @(posedge i_Clk);
    #1;
  endtask

  // Both ports requesting back to back; the winner re-requests a fresh read or write.
  task automatic runContention(input int n);
    logic [15:0] i_a, d_a, d_w, exp_rd;
    bit          d_rw, exp_d, got_i, got_d;
    int          cyc, last_ack, waitc;
    i_a = 16'($urandom_range(0, WORDS - 1));
    d_a = 16'($urandom_range(0, WORDS - 1));
    d_w = 16'($urandom);
    d_rw = 1'($urandom_range(0, 1));
    applyStimulus(1'b1, i_a, 1'b1, d_rw, d_a, d_w);
    cyc = 0; last_ack = 0;
    for (int k = 0; k < n; k++) begin
      waitc = 0; got_i = 1'b0; got_d = 1'b0;
      while (!(got_i || got_d) && waitc < 20) begin
        @(posedge i_Clk); #1;
        cyc++; waitc++;
        got_i = bus.I_ACK;
        got_d = bus.D_ACK;
      end
      exp_d  = !ref_last_d;
      exp_rd = (exp_d && d_rw) ? last_rdata : ref_mem[exp_d ? d_a : i_a];
      checkOutput("cont_overlap", got_i && got_d, 0);
      checkOutput("cont_port_d", got_d, exp_d);
      checkOutput("cont_port_i", got_i, !exp_d);
      checkOutput("cont_err", bus.ERR, 0);
      checkOutput("cont_rdata", bus.RDATA, exp_rd);
      checkOutput("cont_spacing", (k == 0) ? cyc : cyc - last_ack, (k == 0) ? 3 : 4);
      last_ack = cyc;
      ref_last_d = exp_d;
      if (exp_d && d_rw) ref_mem[d_a] = d_w;
      last_rdata = exp_rd;
      if (k == n - 1) begin
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0);
      end else begin
        if (exp_d) begin
          d_a = 16'($urandom_range(0, WORDS - 1));
          d_w = 16'($urandom);
          d_rw = 1'($urandom_range(0, 1));
        end else begin
          i_a = 16'($urandom_range(0, WORDS - 1));
        end
        applyStimulus(1'b1, i_a, 1'b1, d_rw, d_a, d_w);
      end
    end
    repeat (3) @(posedge i_Clk);
    #1;
  endtask

  initial begin
    bit          found, is_d, rw;
    logic [15:0] addr, wdata, last_wr;
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0);
    for (int a = 0; a < 65536; a++) ref_mem[a] = init_val(16'(a));
    last_wr = 16'h0100;

    repeat (3) @(posedge i_Clk);
    #1;
    checkOutput("rst_memen", bus.MEM_EN, 0);
    checkOutput("rst_rw", bus.RW, 0);
    checkOutput("rst_acks", {bus.I_ACK, bus.D_ACK}, 0);
    checkOutput("rst_err", bus.ERR, 0);
    checkOutput("rst_mar", bus.MAR_OUT, 0);
    checkOutput("rst_mdr", bus.MDR_OUT, 0);
    checkOutput("rst_rdata", bus.RDATA, 0);
    i_Rst_n = 1'b1;
    @(posedge i_Clk); #1;

    runSingle("fetch", 1'b0, 1'b0, 16'h3000, 16'd0, 1'b0);
    checkOutput("fetch_value", bus.RDATA, 16'h1234);
    runSingle("store", 1'b1, 1'b1, 16'h0100, 16'hBEEF, 1'b0);
    runSingle("load", 1'b1, 1'b0, 16'h0100, 16'd0, 1'b0);
    checkOutput("load_value", bus.RDATA, 16'hBEEF);
    runSingle("oor", 1'b1, 1'b0, 16'h7080, 16'd0, 1'b0);
    runSingle("edge_last", 1'b0, 1'b0, 16'h707F, 16'd0, 1'b0);
    runSingle("d_prime", 1'b1, 1'b0, 16'h0050, 16'd0, 1'b0);

    runContention(4);

    mem_hold = 1'b1;
    runSingle("timeout", 1'b0, 1'b0, 16'h0010, 16'd0, 1'b1);
    mem_hold = 1'b0;
    runSingle("after_tmo", 1'b0, 1'b0, 16'h0010, 16'd0, 1'b0);

    for (int n = 0; n < 16; n++) begin
      is_d  = 1'($urandom_range(0, 1));
      rw    = is_d ? 1'($urandom_range(0, 1)) : 1'b0;
      wdata = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       addr = 16'(WORDS + $urandom_range(0, 65535 - WORDS));
        1:       addr = last_wr;
        default: addr = 16'($urandom_range(0, WORDS - 1));
      endcase
      if (rw && addr < 16'(WORDS)) last_wr = addr;
      runSingle("rand", is_d, rw, addr, wdata, 1'b0);
    end

    runContention(6);

    applyStimulus(1'b1, 16'h0200, 1'b0, 1'b0, 16'd0, 16'd0);
    found = 1'b0;
    for (int w = 0; w < 10 && !found; w++) begin
      @(posedge i_Clk); #1;
      if (bus.MEM_EN && bus.R) found = 1'b1;
    end
    checkOutput("rst_mid_window", found, 1);
    #1 i_Rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_memen", bus.MEM_EN, 0);
    checkOutput("rst_mid_acks", {bus.I_ACK, bus.D_ACK, bus.ERR}, 0);
    checkOutput("rst_mid_rdata", bus.RDATA, 0);
    #1 i_Rst_n = 1'b1;
    ref_last_d = 1'b1;
    last_rdata = 16'd0;
    @(posedge i_Clk); #1;
    checkOutput("rst_no_grant_while_r", bus.MEM_EN, 0);
    runSingle("rst_resume", 1'b0, 1'b0, 16'h0200, 16'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
